bin2bcd_seq: RTL

//   Complete sequential binary-to-BCD converter (shift-and-add-3 / double dabble) with datapath and FSM in one block.

---
 rtl/bin2bcd_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with valid/ready handshakes,
// optional two's-complement input and sticky overflow for truncated results.
module bin2bcd_seq #(
    parameter int BIN_W       = 16,
    parameter int BCD_DIGITS  = 5,
    parameter int SIGNED_MODE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BIN_W-1:0]          bin_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*BCD_DIGITS-1:0]   bcd_out,
    output logic                      sign_out,
    output logic                      ovf,
    output logic                      busy
);

    localparam int ACC_W = 4 * BCD_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADJUST = 2'd1,
        S_SHIFT  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [BIN_W-1:0]   opnd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sign_acc_q;
    logic               ovf_acc_q;
    logic [ACC_W-1:0]   bcd_q;
    logic               sign_q;
    logic               ovf_q;
    logic               out_valid_q;

    logic               neg_d;
    logic [BIN_W-1:0]   mag_d;
    logic [ACC_W-1:0]   acc_adj_d;

    // Each digit >= 5 gets +3 inside its own nibble; no carry crosses digits.
    function automatic logic [ACC_W-1:0] add3_digits(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = a;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (a[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = a[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Operand magnitude and per-digit adjustment of the accumulator.
    always_comb begin
        neg_d     = 1'b0;
        mag_d     = bin_in;
        acc_adj_d = add3_digits(acc_q);
        if ((SIGNED_MODE != 0) && bin_in[BIN_W-1]) begin
            neg_d = 1'b1;
            mag_d = (~bin_in) + {{(BIN_W-1){1'b0}}, 1'b1};
        end else begin
            neg_d = 1'b0;
            mag_d = bin_in;
        end
    end

    // Control FSM and conversion datapath; results are captured once per DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            acc_q       <= {ACC_W{1'b0}};
            opnd_q      <= {BIN_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            sign_acc_q  <= 1'b0;
            ovf_acc_q   <= 1'b0;
            bcd_q       <= {ACC_W{1'b0}};
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        opnd_q     <= mag_d;
                        sign_acc_q <= neg_d;
                        acc_q      <= {ACC_W{1'b0}};
                        ovf_acc_q  <= 1'b0;
                        cnt_q      <= CNT_W'(BIN_W);
                        state_q    <= S_ADJUST;
                    end else begin
                        state_q    <= S_IDLE;
                    end
                end
                S_ADJUST: begin
                    acc_q   <= acc_adj_d;
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    // A set top bit after adjustment is a carry out of the top digit.
                    if (acc_q[ACC_W-1]) begin
                        ovf_acc_q <= 1'b1;
                    end else begin
                        ovf_acc_q <= ovf_acc_q;
                    end
                    acc_q  <= {acc_q[ACC_W-2:0], opnd_q[BIN_W-1]};
                    opnd_q <= {opnd_q[BIN_W-2:0], 1'b0};
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_ADJUST;
                    end
                end
                S_DONE: begin
                    if (!out_valid_q) begin
                        bcd_q       <= acc_q;
                        sign_q      <= sign_acc_q;
                        ovf_q       <= ovf_acc_q;
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign bcd_out   = bcd_q;
    assign sign_out  = sign_q;
    assign ovf       = ovf_q;

endmodule
